// File: rtl/cla_pkg.sv
// Shared types, defaults and the group propagate/generate helper for the
// pipelined lookahead add/sub slice.
package cla_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_GROUP = 4;
  // Widest vector the group helper folds; bounds both group size and group count.
  localparam int unsigned MAX_GROUP     = 32;

  // Group-level propagate/generate pair.
  typedef struct packed {
    logic gp;
    logic gg;
  } group_pg_t;

  // Width-independent part of the stage-1 payload; p/g vectors ride beside it.
  typedef struct packed {
    logic cin;
    logic a_msb;
    logic b_msb;
    logic sub;
  } s1_ctrl_t;

  // Fold the low n bits of p/g into a group propagate and lookahead generate.
  function automatic group_pg_t group_pg(input logic [MAX_GROUP-1:0] p,
                                         input logic [MAX_GROUP-1:0] g,
                                         input int unsigned          n);
    group_pg_t            r;
    logic [MAX_GROUP-1:0] pv;
    logic [MAX_GROUP-1:0] gv;
    r.gp = 1'b1;
    r.gg = 1'b0;
    pv   = p;
    gv   = g;
    for (int unsigned i = 0; i < MAX_GROUP; i++) begin
      if (i < n) begin
        r.gg = gv[0] | (pv[0] & r.gg);
        r.gp = r.gp & pv[0];
      end
      pv = pv >> 1;
      gv = gv >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One lookahead group: per-bit carries from the group carry-in, plus the
// group propagate/generate for the next lookahead level.
module cla_group
  import cla_pkg::*;
#(
  parameter int unsigned N = DEFAULT_GROUP
) (
  input  logic [N-1:0] p,
  input  logic [N-1:0] g,
  input  logic         ci,
  output logic [N-1:0] c_c,
  output logic         gp_c,
  output logic         gg_c
);

  group_pg_t pg_all;

  // Group P/G never depend on ci, so the carry network stays acyclic.
  assign pg_all = group_pg(MAX_GROUP'(p), MAX_GROUP'(g), N);
  assign gp_c   = pg_all.gp;
  assign gg_c   = pg_all.gg;

  // Carry into bit i as a flat sum of products over bits below i.
  for (genvar i = 0; i < N; i++) begin : g_carry
    group_pg_t pg_lo;
    assign pg_lo  = group_pg(MAX_GROUP'(p), MAX_GROUP'(g), i);
    assign c_c[i] = pg_lo.gg | (pg_lo.gp & ci);
  end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// on both sides. Stage 1 holds p/g terms, stage 2 holds result and flags.
// Optional: define CLA_ADDSUB_SAT_EN to saturate the result on signed overflow.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned GROUP = DEFAULT_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NGROUPS = WIDTH / GROUP;

  // Stage 1 state
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] g_q, g_d;
  s1_ctrl_t         ctrl_q, ctrl_d;
  logic             s1_valid_q, s1_valid_d;

  // Stage 2 state
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  // Combinational internals
  logic             s2_adv_c;
  logic             accept_c;
  logic [WIDTH-1:0] b_eff_c;
  logic [NGROUPS-1:0] grp_p_c;
  logic [NGROUPS-1:0] grp_g_c;
  logic [NGROUPS-1:0] grp_cin_c;
  logic               top_gp_c;
  logic               top_gg_c;
  logic [WIDTH-1:0]   bit_c_c;
  logic [WIDTH-1:0]   sum_c;
  logic [WIDTH-1:0]   res_c;
  logic               raw_cout_c;
  logic               ovf_c;

  // Handshake: stage 2 advances when it is empty or being drained.
  always_comb begin
    s2_adv_c = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !rst && (!s1_valid_q || s2_adv_c);
    accept_c = in_valid && in_ready;
  end

  // Stage 1 next state: condition B for subtract and capture p/g terms.
  always_comb begin
    b_eff_c    = sub ? ~b : b;
    p_d        = p_q;
    g_d        = g_q;
    ctrl_d     = ctrl_q;
    s1_valid_d = s1_valid_q;
    if (accept_c) begin
      p_d          = a ^ b_eff_c;
      g_d          = a & b_eff_c;
      ctrl_d.cin   = sub;
      ctrl_d.a_msb = a[WIDTH-1];
      ctrl_d.b_msb = b_eff_c[WIDTH-1];
      ctrl_d.sub   = sub;
      s1_valid_d   = 1'b1;
    end else if (s2_adv_c) begin
      s1_valid_d = 1'b0;
    end
  end

  // Second-level lookahead over group P/G yields each group's carry-in.
  cla_group #(.N(NGROUPS)) u_grp_carry (
    .p    (grp_p_c),
    .g    (grp_g_c),
    .ci   (ctrl_q.cin),
    .c_c  (grp_cin_c),
    .gp_c (top_gp_c),
    .gg_c (top_gg_c)
  );

  // First-level groups: bit carries within each group from its carry-in.
  for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
    cla_group #(.N(GROUP)) u_grp (
      .p    (p_q[k*GROUP +: GROUP]),
      .g    (g_q[k*GROUP +: GROUP]),
      .ci   (grp_cin_c[k]),
      .c_c  (bit_c_c[k*GROUP +: GROUP]),
      .gp_c (grp_p_c[k]),
      .gg_c (grp_g_c[k])
    );
  end

  // Sum, carry-out and signed overflow from the stage-1 terms.
  always_comb begin
    sum_c      = p_q ^ bit_c_c;
    raw_cout_c = top_gg_c | (top_gp_c & ctrl_q.cin);
    ovf_c      = (ctrl_q.a_msb == ctrl_q.b_msb) && (sum_c[WIDTH-1] != ctrl_q.a_msb);
`ifdef CLA_ADDSUB_SAT_EN
    if (ovf_c) begin
      res_c = ctrl_q.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_c = sum_c;
    end
`else
    res_c = sum_c;
`endif
  end

  // Stage 2 next state: load on advance, otherwise hold; drop valid once consumed.
  always_comb begin
    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    if (s2_adv_c) begin
      result_d    = res_c;
      carry_d     = raw_cout_c ^ ctrl_q.sub;
      ovf_d       = ovf_c;
      zero_d      = (res_c == '0);
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q         <= '0;
      g_q         <= '0;
      ctrl_q      <= '0;
      s1_valid_q  <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      g_q         <= g_d;
      ctrl_q      <= ctrl_d;
      s1_valid_q  <= s1_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe (WIDTH=16, GROUP=4) against an
// arithmetic reference model and an in-order scoreboard.
module tb_cla_addsub_pipe;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;
  logic         zero;

  int checks;
  int failures;

  typedef struct packed {
    logic [W-1:0] res;
    logic         carry;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t sb_q[$];

  cla_addsub_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t e;
    int   sx;
    int   sy;
    int   sr;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      sr      = sx - sy;
      e.res   = x - y;
      e.carry = (x < y);
    end else begin
      sr      = sx + sy;
      e.res   = x + y;
      e.carry = (int'(x) + int'(y)) > 65535;
    end
    e.ovf = (sr > 32767) || (sr < -32768);
`ifdef CLA_ADDSUB_SAT_EN
    if (e.ovf) e.res = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Observe one cycle mid-period, log accepted ops, then step past the next edge.
  task automatic edge_obs(output logic acc, output logic drn, output logic ov, output exp_t obs);
    @(negedge clk);
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    ov  = out_valid;
    obs = {result, carry, ovf, zero};
    if (acc) sb_q.push_back(model(a, b, sub));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if ({out_valid, result, carry, ovf, zero} !== '0)
      begin failures++; $display("FAIL reset_outputs: got v=%b r=%h c=%b o=%b z=%b want all 0", out_valid, result, carry, ovf, zero); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{16'h7FFF, 16'h0003, 16'h1234, 16'hFFFF, 16'h8000, 16'h8000};
    logic [W-1:0] tb [6] = '{16'h0001, 16'h0005, 16'h1234, 16'h0001, 16'h0001, 16'h8000};
    logic         ts [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef CLA_ADDSUB_SAT_EN
    exp_t te [6] = '{{16'h7FFF, 1'b0, 1'b1, 1'b0}, {16'hFFFE, 1'b1, 1'b0, 1'b0},
                     {16'h0000, 1'b0, 1'b0, 1'b1}, {16'h0000, 1'b1, 1'b0, 1'b1},
                     {16'h8000, 1'b0, 1'b1, 1'b0}, {16'h8000, 1'b1, 1'b1, 1'b0}};
`else
    exp_t te [6] = '{{16'h8000, 1'b0, 1'b1, 1'b0}, {16'hFFFE, 1'b1, 1'b0, 1'b0},
                     {16'h0000, 1'b0, 1'b0, 1'b1}, {16'h0000, 1'b1, 1'b0, 1'b1},
                     {16'h7FFF, 1'b0, 1'b1, 1'b0}, {16'h0000, 1'b1, 1'b1, 1'b1}};
`endif
    logic acc, drn, ov;
    exp_t obs;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = ta[i]; b = tb[i]; sub = ts[i]; in_valid = 1'b1;
      edge_obs(acc, drn, ov, obs);
      checks++;
      if (acc !== 1'b1) begin failures++; $display("FAIL dir_accept op%0d: got %b want 1", i, acc); end
      in_valid = 1'b0;
      edge_obs(acc, drn, ov, obs);
      checks++;
      if (ov !== 1'b0) begin failures++; $display("FAIL dir_latency_early op%0d: out_valid %b want 0", i, ov); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL dir_latency op%0d: out_valid %b want 1", i, out_valid); end
      checks++;
      if ({result, carry, ovf, zero} !== te[i])
        begin failures++; $display("FAIL dir_value op%0d: got %h want %h", i, {result, carry, ovf, zero}, te[i]); end
      @(posedge clk); #1;
      sb_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic acc, drn, ov;
    exp_t obs, e;
    int   got = 0;
    int   first = -1;
    int   last = -1;
    sb_q.delete();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 8) begin
        in_valid = 1'b1; a = pick_operand(); b = pick_operand(); sub = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      edge_obs(acc, drn, ov, obs);
      if (cyc < 8) begin
        checks++;
        if (acc !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc%0d: got %b want 1", cyc, acc); end
      end
      if (drn) begin
        if (first < 0) first = cyc;
        last = cyc;
        got++;
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL b2b_extra: got %h want none", obs); end
        else begin
          e = sb_q.pop_front();
          if (obs !== e) begin failures++; $display("FAIL b2b_result: got %h want %h", obs, e); end
        end
      end
    end
    checks++;
    if (got != 8 || (last - first) != 7)
      begin failures++; $display("FAIL b2b_count: got %0d outputs over %0d cycles want 8 over 8", got, last - first + 1); end
  endtask

  task automatic test_stall();
    logic [W-1:0] oa [3];
    logic [W-1:0] ob [3];
    logic         os [3];
    logic acc, drn, ov;
    exp_t obs, e, snap;
    int   got = 0;
    sb_q.delete();
    snap = '0;
    for (int i = 0; i < 3; i++) begin oa[i] = pick_operand(); ob[i] = pick_operand(); os[i] = 1'($urandom); end
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = oa[i]; b = ob[i]; sub = os[i];
      edge_obs(acc, drn, ov, obs);
      checks++;
      if (acc !== 1'b1) begin failures++; $display("FAIL stall_fill op%0d: accept %b want 1", i, acc); end
    end
    a = oa[2]; b = ob[2]; sub = os[2];
    for (int cyc = 0; cyc < 5; cyc++) begin
      edge_obs(acc, drn, ov, obs);
      checks++;
      if (acc !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc%0d: accept %b want 0", cyc, acc); end
      checks++;
      if (ov !== 1'b1) begin failures++; $display("FAIL stall_out_valid cyc%0d: got %b want 1", cyc, ov); end
      if (cyc == 0) snap = obs;
      else begin
        checks++;
        if (obs !== snap) begin failures++; $display("FAIL stall_stable cyc%0d: got %h want %h", cyc, obs, snap); end
      end
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      edge_obs(acc, drn, ov, obs);
      if (acc) in_valid = 1'b0;
      if (drn) begin
        got++;
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL stall_extra: got %h want none", obs); end
        else begin
          e = sb_q.pop_front();
          if (obs !== e) begin failures++; $display("FAIL stall_result: got %h want %h", obs, e); end
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 3) begin failures++; $display("FAIL stall_count: got %0d want 3", got); end
  endtask

  task automatic test_reset_midflight();
    logic acc, drn, ov;
    exp_t obs;
    sb_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = pick_operand(); b = pick_operand(); sub = 1'($urandom);
      edge_obs(acc, drn, ov, obs);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== '0)
      begin failures++; $display("FAIL rstmid_flush: got v=%b r=%h want v=0 r=0000", out_valid, result); end
    sb_q.delete();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready_after: got %b want 1", in_ready); end
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      edge_obs(acc, drn, ov, obs);
      checks++;
      if (ov !== 1'b0) begin failures++; $display("FAIL rstmid_stale cyc%0d: out_valid %b want 0", cyc, ov); end
    end
  endtask

  task automatic test_random();
    logic acc, drn, ov;
    exp_t obs, e, prev;
    logic prev_stall = 1'b0;
    logic last_acc = 1'b0;
    sb_q.delete();
    prev = '0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        a = pick_operand(); b = pick_operand(); sub = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      edge_obs(acc, drn, ov, obs);
      last_acc = acc;
      if (prev_stall) begin
        checks++;
        if (ov !== 1'b1 || obs !== prev)
          begin failures++; $display("FAIL rand_hold cyc%0d: got v=%b %h want v=1 %h", cyc, ov, obs, prev); end
      end
      prev_stall = ov && !out_ready;
      prev = obs;
      if (drn) begin
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL rand_extra cyc%0d: got %h want none", cyc, obs); end
        else begin
          e = sb_q.pop_front();
          if (obs !== e) begin failures++; $display("FAIL rand_result cyc%0d: got %h want %h", cyc, obs, e); end
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      edge_obs(acc, drn, ov, obs);
      if (drn) begin
        checks++;
        if (sb_q.size() == 0) begin failures++; $display("FAIL rand_drain_extra: got %h want none", obs); end
        else begin
          e = sb_q.pop_front();
          if (obs !== e) begin failures++; $display("FAIL rand_drain_result: got %h want %h", obs, e); end
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL rand_lost: %0d results outstanding want 0", sb_q.size()); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
